// File: rtl/mm_pkg.sv
// Shared types for the Montgomery exponentiation controller: FSM states and y-operand selects.
// Latency: n/a (types and helpers only).
// Backpressure: n/a. Conversion states exist only when MM_ME_FROM_MONT_EN is defined.
package mm_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SQR       = 3'd1,
      SQR_WAIT  = 3'd2,
      MUL       = 3'd3,
      MUL_WAIT  = 3'd4,
`ifdef MM_ME_FROM_MONT_EN
      CONV      = 3'd5,
      CONV_WAIT = 3'd6,
`endif
      DONE      = 3'd7
   } me_state_e;

   // x is always the accumulator; only y needs a select
   typedef enum logic [1:0] {
      SEL_ACC  = 2'd0,
      SEL_BASE = 2'd1,
      SEL_ONE  = 2'd2
   } y_sel_e;

   // bit-index width, kept at least 1 bit for a degenerate 1-bit exponent
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mm_me_ctrl_if.sv
// Operand/result bus between the exponentiation controller and the external Montgomery multiplier.
// Latency: n/a (wires only).
// Backpressure: none; one request in flight, completion signalled by mm_val.
interface mm_me_ctrl_if #(
   parameter int K = 4096
) ();
   logic [K-1:0] mm_x;
   logic [K-1:0] mm_y;
   logic [K-1:0] mm_m;
   logic         mm_req;
   logic [K-1:0] mm_res;
   logic         mm_val;

   modport master (
      output mm_x, mm_y, mm_m, mm_req,
      input  mm_res, mm_val
   );

   modport slave (
      input  mm_x, mm_y, mm_m, mm_req,
      output mm_res, mm_val
   );
endinterface

// File: rtl/mm_me_opsel.sv
// Registered operand mux placing acc/base_m/1 onto the multiplier x/y operands.
// Latency: 1 cycle, operands valid in the cycle after load (the mm_req cycle).
// Backpressure: none; operands hold until the next load, so they stay stable while a multiply runs.
module mm_me_opsel
   import mm_pkg::*;
#(
   parameter int K = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  y_sel_e       y_sel,
   input  logic [K-1:0] acc_nxt,
   input  logic [K-1:0] base_q,
   output logic [K-1:0] x,
   output logic [K-1:0] y
);

   localparam logic [K-1:0] ONE = {{(K-1){1'b0}}, 1'b1};

   logic [K-1:0] y_nxt;

   // select the y operand for the multiply being issued
   always_comb begin
      y_nxt = acc_nxt;
      case (y_sel)
         SEL_BASE: y_nxt = base_q;
         SEL_ONE:  y_nxt = ONE;
         default:  y_nxt = acc_nxt;
      endcase
   end

   // capture operands only when a new multiply is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (load) begin
         x <= acc_nxt;
         y <= y_nxt;
      end
   end

endmodule

// File: rtl/mm_me_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation controller driving an external Montgomery multiplier.
// Latency: E + popcount(e) multiplies (+1 when MM_ME_FROM_MONT_EN adds the final from-Montgomery step) plus ~2 cycles.
// Backpressure: one multiply in flight, waits on mm_val; start ignored while busy.
module mm_me_ctrl
   import mm_pkg::*;
#(
   parameter int K = 4096,
   parameter int E = 4096
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [K-1:0]  base_m,
   input  logic [K-1:0]  one_m,
   input  logic [E-1:0]  e,
   input  logic [K-1:0]  m,
   mm_me_ctrl_if.master  mm,
   output logic [K-1:0]  res,
   output logic          val,
   output logic          busy
);

   localparam int             IW      = idx_width(E);
   localparam logic [IW-1:0]  IDX_TOP = IW'(E - 1);
   localparam logic [IW-1:0]  IDX_ONE = IW'(1);

   me_state_e     state_q, state_d;
   logic [K-1:0]  acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [K-1:0]  base_q;
   logic [K-1:0]  m_q;
   logic [E-1:0]  e_q;
   logic [K-1:0]  res_q;
   logic          req_q;
   logic          val_q;
   logic          load;
   logic          leave;
   y_sel_e        y_sel;
   logic [K-1:0]  x_w, y_w;

   // next state, accumulator capture, bit index and multiply issue
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      load    = 1'b0;
      leave   = 1'b0;
      y_sel   = SEL_ACC;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = one_m;
               idx_d   = IDX_TOP;
               load    = 1'b1;
               state_d = SQR;
            end
         end
         SQR: state_d = SQR_WAIT;
         SQR_WAIT: begin
            if (mm.mm_val) begin
               acc_d = mm.mm_res;
               if (e_q[idx_q]) begin
                  y_sel   = SEL_BASE;
                  load    = 1'b1;
                  state_d = MUL;
               end else if (idx_q == '0) begin
                  leave = 1'b1;
               end else begin
                  idx_d   = idx_q - IDX_ONE;
                  load    = 1'b1;
                  state_d = SQR;
               end
            end
         end
         MUL: state_d = MUL_WAIT;
         MUL_WAIT: begin
            if (mm.mm_val) begin
               acc_d = mm.mm_res;
               if (idx_q == '0) begin
                  leave = 1'b1;
               end else begin
                  idx_d   = idx_q - IDX_ONE;
                  load    = 1'b1;
                  state_d = SQR;
               end
            end
         end
`ifdef MM_ME_FROM_MONT_EN
         CONV: state_d = CONV_WAIT;
         CONV_WAIT: begin
            if (mm.mm_val) begin
               acc_d   = mm.mm_res;
               state_d = DONE;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // loop exit: either one more MM(acc,1) or straight to completion
      if (leave) begin
`ifdef MM_ME_FROM_MONT_EN
         y_sel   = SEL_ONE;
         load    = 1'b1;
         state_d = CONV;
`else
         state_d = DONE;
`endif
      end
   end

   // FSM state, accumulator, bit index, request and completion pulses, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         req_q   <= 1'b0;
         val_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         req_q   <= load;
         val_q   <= (state_d == DONE);
         if (state_d == DONE) begin
            res_q <= acc_d;
         end
      end
   end

   // latch operands on an accepted start; later starts cannot disturb them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         e_q    <= '0;
         m_q    <= '0;
      end else if (state_q == IDLE && start) begin
         base_q <= base_m;
         e_q    <= e;
         m_q    <= m;
      end
   end

   mm_me_opsel #(
      .K(K)
   ) u_opsel (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .y_sel   (y_sel),
      .acc_nxt (acc_d),
      .base_q  (base_q),
      .x       (x_w),
      .y       (y_w)
   );

   assign mm.mm_x   = x_w;
   assign mm.mm_y   = y_w;
   assign mm.mm_m   = m_q;
   assign mm.mm_req = req_q;
   assign res       = res_q;
   assign val       = val_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mm_me_ctrl.sv
// Directed bench for mm_me_ctrl at K=8, E=8, m=0xF1, R=2^8 with a behavioural Montgomery multiplier.
// Latency: multiplier answers two cycles after each request.
// Backpressure: n/a; expected values follow MM_ME_FROM_MONT_EN if defined for the build.
`timescale 1ns/1ps
module tb_mm_me_ctrl;

   localparam int K = 8;
   localparam int E = 8;
`ifdef MM_ME_FROM_MONT_EN
   localparam int         CONV_N = 1;
   localparam logic [7:0] RES_E5 = 8'h02;
   localparam logic [7:0] RES_E0 = 8'h01;
`else
   localparam int         CONV_N = 0;
   localparam logic [7:0] RES_E5 = 8'h1E;
   localparam logic [7:0] RES_E0 = 8'h0F;
`endif

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         start  = 1'b0;
   logic [K-1:0] base_m = '0;
   logic [K-1:0] one_m  = '0;
   logic [E-1:0] e      = '0;
   logic [K-1:0] m      = '0;
   logic [K-1:0] res;
   logic         val;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int req_cnt = 0;
   int val_cnt = 0;
   logic spur = 1'b0;
   logic [7:0] rx, ry;

   mm_me_ctrl_if #(.K(K)) mm ();

   mm_me_ctrl #(.K(K), .E(E)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .base_m (base_m),
      .one_m  (one_m),
      .e      (e),
      .m      (m),
      .mm     (mm),
      .res    (res),
      .val    (val),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   // x*y*R^-1 mod 241, with R^-1 = 225 (256*225 = 1 mod 241)
   function automatic logic [7:0] mont(input logic [7:0] x, input logic [7:0] y);
      int p;
      p = (int'(x) * int'(y) * 225) % 241;
      return 8'(p);
   endfunction

   // pulse counters sampled mid-cycle
   initial forever begin
      @(negedge clk);
      if (mm.mm_req === 1'b1) req_cnt++;
      if (val === 1'b1) val_cnt++;
   end

   // multiplier model; optionally fires a bogus mm_val in the request cycle
   initial begin
      mm.mm_val = 1'b0;
      mm.mm_res = '0;
      forever begin
         @(negedge clk);
         while (mm.mm_req === 1'b1) begin
            rx = mm.mm_x;
            ry = mm.mm_y;
            if (spur) begin
               mm.mm_val = 1'b1;
               mm.mm_res = 8'hAA;
            end
            repeat (2) begin
               @(negedge clk);
               mm.mm_val = 1'b0;
            end
            mm.mm_res = mont(rx, ry);
            mm.mm_val = 1'b1;
            @(negedge clk);
            mm.mm_val = 1'b0;
            mm.mm_res = '0;
         end
      end
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [7:0] b, input logic [7:0] ex);
      @(negedge clk);
      base_m = b;
      e      = ex;
      one_m  = 8'h0F;
      m      = 8'hF1;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_val(input string tag);
      int n = 0;
      while (val !== 1'b1 && n < 600) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(tag, 8'(val), 8'd1);
   endtask

   task automatic wait_req(input string tag, input int target);
      int n = 0;
      while (req_cnt < target && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(tag, 8'(req_cnt >= target), 8'd1);
   endtask

   initial begin
      int r0, v0;

      // reset state
      #2;
      check("rst_res",    res,          8'h00);
      check("rst_val",    8'(val),      8'd0);
      check("rst_busy",   8'(busy),     8'd0);
      check("rst_mm_req", 8'(mm.mm_req), 8'd0);
      check("rst_mm_x",   mm.mm_x,      8'h00);
      check("rst_mm_y",   mm.mm_y,      8'h00);
      check("rst_mm_m",   mm.mm_m,      8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 3^5 mod 241, with a start poked in the val cycle
      r0 = req_cnt; v0 = val_cnt;
      start_op(8'h2D, 8'h05);
      #1;
      check("a_busy_run", 8'(busy),  8'd1);
      check("a_mm_m",     mm.mm_m,   8'hF1);
      wait_val("a_val_seen");
      check("a_res",      res,       RES_E5);
      check("a_busy_val", 8'(busy),  8'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("a_start_at_val_ignored", 8'(busy), 8'd0);
      repeat (4) @(negedge clk);
      #1;
      check("a_req_pulses", 8'(req_cnt - r0), 8'(10 + CONV_N));
      check("a_val_pulses", 8'(val_cnt - v0), 8'd1);
      check("a_res_held",   res,              RES_E5);

      // e = 0 leaves the Montgomery one
      r0 = req_cnt; v0 = val_cnt;
      start_op(8'h2D, 8'h00);
      wait_val("b_val_seen");
      check("b_res", res, RES_E0);
      repeat (3) @(negedge clk);
      #1;
      check("b_req_pulses", 8'(req_cnt - r0), 8'(8 + CONV_N));
      check("b_val_pulses", 8'(val_cnt - v0), 8'd1);

      // spurious mm_val in SQR and a second start while busy
      r0 = req_cnt; v0 = val_cnt;
      spur = 1'b1;
      start_op(8'h2D, 8'h05);
      wait_req("c_first_req", r0 + 1);
      spur = 1'b0;
      wait_req("c_third_req", r0 + 3);
      @(negedge clk);
      base_m = 8'h01;
      e      = 8'hFF;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_val("c_val_seen");
      check("c_res", res, RES_E5);
      repeat (3) @(negedge clk);
      #1;
      check("c_req_pulses", 8'(req_cnt - r0), 8'(10 + CONV_N));
      check("c_val_pulses", 8'(val_cnt - v0), 8'd1);

      // reset while waiting on the first MUL result
      r0 = req_cnt; v0 = val_cnt;
      start_op(8'h2D, 8'h05);
      wait_req("d_mul_req", r0 + 7);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("d_rst_mm_req", 8'(mm.mm_req), 8'd0);
      check("d_rst_mm_x",   mm.mm_x,       8'h00);
      check("d_rst_mm_y",   mm.mm_y,       8'h00);
      check("d_rst_mm_m",   mm.mm_m,       8'h00);
      check("d_rst_res",    res,           8'h00);
      check("d_rst_val",    8'(val),       8'd0);
      check("d_rst_busy",   8'(busy),      8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check("d_idle_after_stale_mm_val", 8'(busy), 8'd0);
      check("d_no_val",     8'(val_cnt - v0), 8'd0);
      check("d_no_new_req", 8'(req_cnt - r0), 8'd7);
      start_op(8'h2D, 8'h05);
      wait_val("d_val_seen");
      check("d_res", res, RES_E5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mm_me_ctrl.md
MM_ME_CTRL -- requirements
Module: mm_me_ctrl

Interface
REQ-001 SHALL have parameter K, default 4096, giving the operand/modulus width in bits.
REQ-002 SHALL have parameter E, default 4096, giving the exponent width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse requesting one exponentiation.
REQ-006 SHALL have port base_m, input, K bits: base in Montgomery form, sampled at accepted start.
REQ-007 SHALL have port one_m, input, K bits: R mod m (Montgomery one), sampled at accepted start.
REQ-008 SHALL have port e, input, E bits: exponent, sampled at accepted start.
REQ-009 SHALL have port m, input, K bits: modulus, sampled at accepted start.
REQ-010 SHALL have port mm_x, output, K bits: multiplier x operand.
REQ-011 SHALL have port mm_y, output, K bits: multiplier y operand.
REQ-012 SHALL have port mm_m, output, K bits: multiplier modulus, equal to the latched m.
REQ-013 SHALL have port mm_req, output, 1 bit: single-cycle request pulse to mm_r2mm_2n.
REQ-014 SHALL have port mm_res, input, K bits: multiplier result, valid while mm_val is high.
REQ-015 SHALL have port mm_val, input, 1 bit: multiplier completion strobe.
REQ-016 SHALL have port res, output, K bits: exponentiation result, held until the next accepted start.
REQ-017 SHALL have port val, output, 1 bit: single-cycle completion pulse.
REQ-018 SHALL have port busy, output, 1 bit: high from accepted start through the val cycle.

Function
REQ-019 SHALL implement left-to-right binary square-and-multiply: acc=one_m; for i=E-1 down to 0: acc=MM(acc,acc); if e[i]=1 then acc=MM(acc,base_m).
REQ-020 SHALL use FSM states IDLE, SQR, SQR_WAIT, MUL, MUL_WAIT, CONV, CONV_WAIT, DONE.
REQ-021 SHALL, in IDLE with start=1, latch all operands, set the bit index to E-1, and go to SQR.
REQ-022 SHALL, in SQR/MUL/CONV, drive the operands and assert mm_req for exactly one cycle, then go to the matching _WAIT state.
REQ-023 SHALL, in a _WAIT state with mm_val=1, capture mm_res into acc in the same edge.
REQ-024 SHALL transition from SQR_WAIT to MUL if e[i]=1; otherwise it decrements i and returns to SQR, or leaves the loop when i=0.
REQ-025 SHALL transition from MUL_WAIT by decrementing i and returning to SQR, or leave the loop when i=0.
REQ-026 SHALL, on leaving the loop, go to CONV when the conversion is compiled in, else to DONE.
REQ-027 SHALL, in DONE, copy acc to res, pulse val for one cycle, and return to IDLE.
REQ-028 SHALL hold mm_x, mm_y, mm_m stable from the mm_req cycle until mm_val.
REQ-029 SHALL ignore start while busy=1; the in-flight operation is unaffected.
REQ-030 SHALL ignore mm_val outside the _WAIT states.
REQ-031 SHALL issue exactly E + popcount(e) (+1 with conversion) mm_req pulses per operation; with e=0 the result is Montgomery one (plain 1 with conversion).
REQ-032 SHALL keep the bit index ceil(log2(E)) bits wide; it never wraps below 0.
REQ-033 SHALL accept a start arriving in the same cycle that val pulses only in the following IDLE cycle; that start is ignored.

Reset
REQ-034 SHALL, while rst_n=0, force state IDLE, mm_req=0, val=0, busy=0, res=0, mm_x=mm_y=mm_m=0, acc=0 and bit index=0.
REQ-035 SHALL abandon an in-flight operation on reset with no val; a pending mm_val after release is ignored.

Configuration
REQ-036 SHALL gate the conversion with macro MM_ME_FROM_MONT_EN: when defined, a final MM(acc,1) converts the result to normal form; when undefined, CONV/CONV_WAIT are absent and res stays in Montgomery form.

Structure
REQ-037 SHALL take the FSM state enum and operand-select encodings from shared package mm_pkg.
REQ-038 SHALL use one sub-module, mm_me_opsel, as the registered operand mux (acc/base_m/1 onto mm_x/mm_y); the multiplier stays external.

Verification (K=8, m=0xF1, R=2^8, one_m=0x0F, bench model MM=x*y*R^-1 mod m; REQ-039 SHALL pass all scenarios)
- base_m=0x2D (3), e=5, E=8, conversion in -> res=0x02, 11 mm_req pulses, one val pulse.
- Same stimulus, conversion out -> res=0x1E, 10 mm_req pulses.
- e=0, conversion in -> res=0x01, 9 mm_req pulses; conversion out -> res=0x0F.
- Second start mid-operation, plus a spurious mm_val pulse in SQR -> both ignored, res=0x02.
- rst_n low during MUL_WAIT -> all outputs 0, no val; a fresh start then gives res=0x02.
